dmem_port_arbiter: RTL and testbench

Arbiter for the single-port data memory shared between the pipelined `CPU` and a debug requester (PDU-side loader/inspector). It sits between `CPU` and `DATA_MEM`. The CPU owns the port by default. A debug access is granted by freezing the CPU through `global_en`, performing one word access, and returning read data over a four-phase req/ack handshake. A programmable guard interval guarantees the CPU forward progress between debug accesses.

---
 rtl/dmem_port_arbiter_if.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 93 +++++++++
 tb/tb_dmem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Shared data-memory port bundle: CPU side, debug requester side and DATA_MEM side.
// The arbiter connects through the slave modport; the surrounding system
// (CPU, debug requester, DATA_MEM) connects through the master modport.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              global_en_in;
    logic              cpu_global_en;
    logic [31:0]       cpu_dmem_addr;
    logic              cpu_dmem_we;
    logic [31:0]       cpu_dmem_wdata;
    logic [31:0]       cpu_dmem_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_d;
    logic [31:0]       mem_spo;

    modport slave (
        input  global_en_in, cpu_dmem_addr, cpu_dmem_we, cpu_dmem_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_spo,
        output cpu_global_en, cpu_dmem_rdata, dbg_ack, dbg_rdata,
        output mem_a, mem_we, mem_d
    );

    modport master (
        output global_en_in, cpu_dmem_addr, cpu_dmem_we, cpu_dmem_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_spo,
        input  cpu_global_en, cpu_dmem_rdata, dbg_ack, dbg_rdata,
        input  mem_a, mem_we, mem_d
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU and a debug requester.
// The CPU owns the port by default; a debug access freezes the CPU, performs
// one word access and answers over a four-phase req/ack handshake. A guard
// interval of MIN_CPU_CYCLES enabled CPU cycles separates debug grants.
// Optional feature: define DMEM_ARB_DBG_WRITE_EN to let the debug port write;
// otherwise the debug port is read-only.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned MIN_CPU_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_port_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  gap_cnt_q;
    logic        dbg_ack_q;
    logic [31:0] dbg_rdata_q;

    logic        grant;
    logic        dbg_owns;
    logic        dbg_mem_we;

    // Guard interval is waived while the CPU is halted from the top level.
    assign grant    = bus.dbg_req & ((gap_cnt_q == '0) | ~bus.global_en_in);
    assign dbg_owns = (state_q != IDLE);

`ifdef DMEM_ARB_DBG_WRITE_EN
    assign dbg_mem_we = bus.dbg_we;
`else
    logic unused_dbg_we;
    assign unused_dbg_we = bus.dbg_we;
    assign dbg_mem_we    = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_dmem_addr[31:ADDR_W+2], bus.cpu_dmem_addr[1:0],
                                bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};

    // Port mux and CPU freeze follow the state directly so reset releases the CPU at once.
    assign bus.mem_a          = dbg_owns ? bus.dbg_addr[ADDR_W+1:2] : bus.cpu_dmem_addr[ADDR_W+1:2];
    assign bus.mem_d          = dbg_owns ? bus.dbg_wdata : bus.cpu_dmem_wdata;
    assign bus.mem_we         = (state_q == IDLE)   ? bus.cpu_dmem_we :
                                (state_q == ACCESS) ? dbg_mem_we : 1'b0;
    assign bus.cpu_global_en  = dbg_owns ? 1'b0 : bus.global_en_in;
    assign bus.cpu_dmem_rdata = bus.mem_spo;
    assign bus.dbg_ack        = dbg_ack_q;
    assign bus.dbg_rdata      = dbg_rdata_q;

    // Handshake FSM with guard counter and registered ack/read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= ACCESS;
                    end
                    if (bus.global_en_in && (gap_cnt_q != '0)) begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                ACCESS: begin
                    dbg_rdata_q <= bus.mem_spo;
                    dbg_ack_q   <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (!bus.dbg_req) begin
                        dbg_ack_q <= 1'b0;
                        gap_cnt_q <= 8'(MIN_CPU_CYCLES);
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed handshake scenarios plus
// randomized CPU/debug traffic compared every cycle against a transaction-level model.
module tb_dmem_port_arbiter;

    localparam int unsigned AW  = 9;
    localparam int unsigned MIN = 4;
`ifdef DMEM_ARB_DBG_WRITE_EN
    localparam bit DBGW = 1'b1;
`else
    localparam bit DBGW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en, cpu_we, req, dwe;
    logic [31:0] cpu_addr, cpu_wdata, daddr, dwdata;
    logic [31:0] mem [512];

    int n_chk  = 0;
    int n_fail = 0;

    dmem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    assign bus.global_en_in   = en;
    assign bus.cpu_dmem_addr  = cpu_addr;
    assign bus.cpu_dmem_we    = cpu_we;
    assign bus.cpu_dmem_wdata = cpu_wdata;
    assign bus.dbg_req        = req;
    assign bus.dbg_we         = dwe;
    assign bus.dbg_addr       = daddr;
    assign bus.dbg_wdata      = dwdata;
    assign bus.mem_spo        = mem[bus.mem_a];

    dmem_port_arbiter #(.ADDR_W(AW), .MIN_CPU_CYCLES(MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // DATA_MEM stand-in: asynchronous read, synchronous write, cleared during reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_d;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: own = cycles the debug side has held the port (0 = CPU owns),
    // since = enabled CPU cycles elapsed after the last debug release (saturating).
    int          m_own;
    int          m_since;
    logic [31:0] m_rdata;
    logic [31:0] shadow [512];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own   = 0;
            m_since = MIN;
            m_rdata = '0;
            for (int i = 0; i < 512; i++) shadow[i] = '0;
        end else if (m_own == 0) begin
            if (cpu_we) shadow[cpu_addr[AW+1:2]] = cpu_wdata;
            if (req && (m_since >= MIN || !en)) m_own = 1;
            else if (en && m_since < MIN) m_since++;
        end else if (m_own == 1) begin
            m_rdata = shadow[daddr[AW+1:2]];
            if (DBGW && dwe) shadow[daddr[AW+1:2]] = dwdata;
            m_own = 2;
        end else if (!req) begin
            m_own   = 0;
            m_since = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic        e_en, e_we;
        logic [31:0] e_a;
        e_en = (m_own == 0) ? en : 1'b0;
        e_a  = (m_own == 0) ? 32'(cpu_addr[AW+1:2]) : 32'(daddr[AW+1:2]);
        e_we = (m_own == 0) ? cpu_we : ((m_own == 1) && DBGW && dwe);
        chk("cpu_global_en", 32'(bus.cpu_global_en), 32'(e_en));
        chk("mem_a", 32'(bus.mem_a), e_a);
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (e_we) chk("mem_d", bus.mem_d, (m_own == 0) ? cpu_wdata : dwdata);
        chk("dbg_ack", 32'(bus.dbg_ack), 32'(m_own >= 2));
        chk("dbg_rdata", bus.dbg_rdata, m_rdata);
        chk("cpu_dmem_rdata", bus.cpu_dmem_rdata, bus.mem_spo);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
    endtask

    // One complete four-phase debug transfer; run = enabled cycles before the ack.
    task automatic dbg_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output int frozen,
                            output int run);
        int to;
        dwe = we; daddr = a; dwdata = wd; req = 1'b1;
        lat = 0; frozen = 0; run = 0;
        while (!bus.dbg_ack && lat < 100) begin
            @(negedge clk);
            if (bus.cpu_global_en) run++; else frozen++;
            step();
            lat++;
        end
        if (!bus.dbg_ack) chk("ack_rise_timeout", 32'(bus.dbg_ack), 32'd1);
        rd  = bus.dbg_rdata;
        req = 1'b0;
        to  = 0;
        while (bus.dbg_ack && to < 100) begin
            @(negedge clk);
            if (!bus.cpu_global_en) frozen++;
            step();
            to++;
        end
        if (bus.dbg_ack) chk("ack_fall_timeout", 32'(bus.dbg_ack), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, frozen, run, to;

        en = 1'b1; cpu_we = 1'b0; req = 1'b0; dwe = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; daddr = '0; dwdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_cpu_en", 32'(bus.cpu_global_en), 32'd1);
        chk("reset_ack", 32'(bus.dbg_ack), 32'd0);
        chk("reset_rdata", bus.dbg_rdata, 32'd0);
        step();

        cpu_store(32'h10, 32'hA5A5_0010);
        chk("cpu_store_word4", mem[4], 32'hA5A5_0010);

        cpu_store(32'h20, 32'hDEAD_BEEF);
        dbg_xfer(1'b0, 32'h20, 32'h0, rd, lat, frozen, run);
        chk("dbg_read_0x20", rd, 32'hDEAD_BEEF);
        chk("ack_latency", 32'(lat), 32'd2);
        chk("frozen_cycles", 32'(frozen), 32'd2);

        // High address bits must be ignored.
        dbg_xfer(1'b1, 32'hF000_0040, 32'h1234_5678, rd, lat, frozen, run);
        chk("guard_run_1", 32'(run >= MIN), 32'd1);
        dbg_xfer(1'b0, 32'h40, 32'h0, rd, lat, frozen, run);
        chk("guard_run_2", 32'(run >= MIN), 32'd1);
`ifdef DMEM_ARB_DBG_WRITE_EN
        chk("dbg_write_readback", rd, 32'h1234_5678);
`else
        chk("readonly_readback", rd, 32'h0);
        chk("readonly_word16", mem[16], 32'h0);
`endif

        // Guard waived while the CPU is halted from the top level.
        en = 1'b0;
        dbg_xfer(1'b0, 32'h10, 32'h0, rd, lat, frozen, run);
        chk("halted_no_gap_lat", 32'(lat), 32'd2);
        chk("halted_read_0x10", rd, 32'hA5A5_0010);
        en = 1'b1;

        // CPU store in the grant cycle commits before the debug read.
        repeat (6) step();
        cpu_addr = 32'h80; cpu_wdata = 32'hCAFE_0080; cpu_we = 1'b1;
        daddr = 32'h80; dwe = 1'b0; req = 1'b1;
        step();
        cpu_we = 1'b0;
        to = 0;
        while (!bus.dbg_ack && to < 100) begin step(); to++; end
        chk("grant_cycle_ack_lat", 32'(to), 32'd1);
        chk("grant_cycle_read", bus.dbg_rdata, 32'hCAFE_0080);
        chk("grant_cycle_mem", mem[32], 32'hCAFE_0080);
        req = 1'b0;
        to = 0;
        while (bus.dbg_ack && to < 100) begin step(); to++; end

        // Asynchronous reset while in DONE.
        repeat (6) step();
        daddr = 32'h10; dwe = 1'b0; req = 1'b1;
        to = 0;
        while (!bus.dbg_ack && to < 100) begin step(); to++; end
        chk("pre_reset_ack", 32'(bus.dbg_ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ack", 32'(bus.dbg_ack), 32'd0);
        chk("async_rst_cpu_en", 32'(bus.cpu_global_en), 32'd1);
        req = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Randomized traffic; the four-phase requester never re-raises while ack is high.
        for (int c = 0; c < 3000; c++) begin
            step();
            en        = ($urandom % 8) != 0;
            cpu_we    = ($urandom % 3) == 0;
            cpu_addr  = ($urandom & ~32'h7FC) | (($urandom % 16) << 2);
            cpu_wdata = $urandom;
            if (req && bus.dbg_ack && ($urandom % 2) == 0) begin
                req = 1'b0;
            end else if (!req && !bus.dbg_ack && ($urandom % 3) == 0) begin
                dwe    = $urandom % 2;
                daddr  = ($urandom & ~32'h7FC) | (($urandom % 16) << 2);
                dwdata = $urandom;
                req    = 1'b1;
            end
        end
        step();
        cpu_we = 1'b0;
        req    = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
